// File: rtl/plot_scheduler_pkg.sv
// Shared screen geometry, scheduler states and colour constants for the
// framebuffer write-port scheduler.
package plot_scheduler_pkg;

  localparam int unsigned SCREEN_W    = 160;
  localparam int unsigned SCREEN_H    = 120;
  localparam int unsigned PIXELS      = SCREEN_W * SCREEN_H;
  localparam int unsigned ROM_LATENCY = 1;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned COLOUR_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    PIXEL
  } state_t;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] RED   = 3'b100;
  localparam logic [COLOUR_W-1:0] CYAN  = 3'b011;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  function automatic logic on_screen(input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
    return (px < X_W'(SCREEN_W)) && (py < Y_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/plot_scheduler_raster_counter.sv
// Raster-order x/y counter: x runs 0..SCREEN_W-1 inner, y 0..SCREEN_H-1 outer,
// with synchronous clear/enable and a flag on the final pixel.
module raster_counter
  import plot_scheduler_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic           enable,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic x_end;
  logic y_end;

  assign x_end = (x == X_W'(SCREEN_W - 1));
  assign y_end = (y == Y_W'(SCREEN_H - 1));
  assign last  = x_end && y_end;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (enable) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/plot_scheduler.sv
// Arbitrates the single framebuffer write port between a full-screen redraw
// from the image ROM and single-pixel write requests.
module plot_scheduler
  import plot_scheduler_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                fill_req,
  output logic                fill_busy,
  output logic                fill_done,
  input  logic                px_req,
  input  logic [X_W-1:0]      px_x,
  input  logic [Y_W-1:0]      px_y,
  input  logic [COLOUR_W-1:0] px_colour,
  output logic                px_ack,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic                plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour
);

  state_t                state;
  logic                  fill_pending;
  logic                  colour_from_rom;
  logic [COLOUR_W-1:0]   pixel_colour;
  logic                  cnt_clear;
  logic                  cnt_enable;
  logic                  cnt_last;
  logic [X_W-1:0]        cnt_x;
  logic [Y_W-1:0]        cnt_y;

  // Counter rests at (0,0) whenever no redraw is scanning, so FILL always starts there.
  assign cnt_clear  = (state != FILL);
  assign cnt_enable = (state == FILL) && !cnt_last;

  raster_counter u_raster (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .x      (cnt_x),
    .y      (cnt_y),
    .last   (cnt_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      fill_pending    <= 1'b0;
      plot            <= 1'b0;
      px_ack          <= 1'b0;
      fill_busy       <= 1'b0;
      fill_done       <= 1'b0;
      colour_from_rom <= 1'b0;
      x               <= '0;
      y               <= '0;
      pixel_colour    <= BLACK;
      rom_addr        <= '0;
    end else begin
      plot            <= 1'b0;
      px_ack          <= 1'b0;
      fill_done       <= 1'b0;
      colour_from_rom <= 1'b0;
      unique case (state)
        IDLE: begin
          if (px_req) begin
            state        <= PIXEL;
            px_ack       <= 1'b1;
            plot         <= on_screen(px_x, px_y);
            x            <= px_x;
            y            <= px_y;
            pixel_colour <= px_colour;
            fill_pending <= fill_req;
          end else if (fill_req) begin
            state     <= FILL;
            fill_busy <= 1'b1;
            rom_addr  <= '0;
          end
        end
        PIXEL: begin
          if (fill_pending || fill_req) begin
            state        <= FILL;
            fill_busy    <= 1'b1;
            rom_addr     <= '0;
            fill_pending <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        FILL: begin
          // Coordinates trail rom_addr by the ROM latency so they meet rom_data.
          plot            <= 1'b1;
          colour_from_rom <= 1'b1;
          x               <= cnt_x;
          y               <= cnt_y;
          if (cnt_last) begin
            state     <= DRAIN;
            fill_done <= 1'b1;
          end else begin
            rom_addr <= rom_addr + 1'b1;
          end
        end
        DRAIN: begin
          state     <= IDLE;
          fill_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The ROM output is itself registered; redraw plots take it straight through.
  assign colour = colour_from_rom ? rom_data : pixel_colour;

endmodule

// File: tb/tb_plot_scheduler.sv
// Directed/randomized bench for plot_scheduler against a raster-order reference model.
module tb_plot_scheduler;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic        clock = 1'b0;
  logic        reset;
  logic        fill_req;
  logic        fill_busy;
  logic        fill_done;
  logic        px_req;
  logic [7:0]  px_x;
  logic [6:0]  px_y;
  logic [2:0]  px_colour;
  logic        px_ack;
  logic [14:0] rom_addr;
  logic [2:0]  rom_data = '0;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;

  logic [2:0]  salt = '0;
  int          errors = 0;
  int          checks = 0;

  plot_scheduler dut (
    .clock     (clock),
    .reset     (reset),
    .fill_req  (fill_req),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .px_req    (px_req),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_colour (px_colour),
    .px_ack    (px_ack),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .plot      (plot),
    .x         (x),
    .y         (y),
    .colour    (colour)
  );

  always #10 clock = ~clock;

  // Image ROM: one-cycle read latency, contents addr[2:0] scrambled by salt.
  always @(posedge clock) rom_data <= rom_addr[2:0] ^ salt;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs k cycles after the cycle in which a redraw was accepted.
  task automatic run_fill(input int px_at, input int refill_at, input int abort_at,
                          input logic [7:0] qx, input logic [6:0] qy, input logic [2:0] qc);
    for (int k = 1; k <= N + 2; k++) begin
      logic exp_busy, exp_plot, exp_done;
      int   p;
      exp_busy = (k >= 1) && (k <= N + 1);
      exp_plot = (k >= 2) && (k <= N + 1);
      exp_done = (k == N + 1);
      chk("fill_ctl", {plot, fill_busy, fill_done, px_ack},
          {exp_plot, exp_busy, exp_done, 1'b0});
      if (exp_plot) begin
        p = k - 2;
        chk("fill_pix", {x, y, colour}, {8'(p % W), 7'(p / W), 3'(p) ^ salt});
        if (salt == 3'd0 && p == 5)
          chk("pix_5_0", {x, y, colour}, {8'd5, 7'd0, 3'b101});
      end
      if (k <= N) chk("fill_addr", rom_addr, 64'(k - 1));
      else        chk("addr_bound", 64'(rom_addr <= 15'd19199), 64'd1);
      if (k == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_out", {plot, fill_busy, fill_done, px_ack, rom_addr}, 64'd0);
        for (int j = 0; j < 4; j++) begin
          tick();
          chk("abort_quiet", {plot, fill_busy, fill_done}, 64'd0);
        end
        return;
      end
      if (k == px_at) begin
        px_req    = 1'b1;
        px_x      = qx;
        px_y      = qy;
        px_colour = qc;
      end
      fill_req = (k == refill_at);
      if (k < N + 2) tick();
    end
  endtask

  task automatic check_pixel(input string tag, input logic [7:0] qx, input logic [6:0] qy,
                             input logic [2:0] qc);
    logic vis;
    vis = (qx < 8'd160) && (qy < 7'd120);
    chk({tag, "_ctl"}, {plot, fill_busy, fill_done, px_ack}, {vis, 1'b0, 1'b0, 1'b1});
    if (vis) chk({tag, "_xyc"}, {x, y, colour}, {qx, qy, qc});
  endtask

  task automatic do_pixel(input logic [7:0] qx, input logic [6:0] qy, input logic [2:0] qc);
    px_req = 1'b1; px_x = qx; px_y = qy; px_colour = qc;
    tick();
    check_pixel("pixel", qx, qy, qc);
    px_req = 1'b0;
    tick();
    chk("pixel_once", {plot, px_ack}, 64'd0);
  endtask

  initial begin
    logic [7:0] rx;
    logic [6:0] ry;
    logic [2:0] rc;
    reset = 1'b1; fill_req = 1'b0; px_req = 1'b0;
    px_x = '0; px_y = '0; px_colour = '0;
    tick();
    tick();
    chk("reset_out", {plot, px_ack, fill_busy, fill_done, x, y, colour, rom_addr}, 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_out", {plot, px_ack, fill_busy, fill_done}, 64'd0);

    do_pixel(8'd10, 7'd20, 3'b100);
    do_pixel(8'd160, 7'd0, 3'b111);
    do_pixel(8'd159, 7'd119, 3'b011);
    do_pixel(8'd0, 7'd120, 3'b001);
    for (int i = 0; i < 8; i++) begin
      rx = 8'($urandom_range(0, 175));
      ry = 7'($urandom_range(0, 127));
      rc = 3'($urandom);
      do_pixel(rx, ry, rc);
    end

    // Full redraw with the plain addr[2:0] image.
    salt = 3'd0;
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    run_fill(0, 0, 0, '0, '0, '0);

    // Pixel and redraw requested together: pixel first, redraw follows unprompted.
    salt = 3'($urandom);
    rx = 8'($urandom_range(0, 159));
    ry = 7'($urandom_range(0, 119));
    rc = 3'($urandom);
    fill_req = 1'b1; px_req = 1'b1; px_x = rx; px_y = ry; px_colour = rc;
    tick();
    check_pixel("both_pixel", rx, ry, rc);
    fill_req = 1'b0; px_req = 1'b0;
    tick();
    run_fill(0, 0, 0, '0, '0, '0);

    // Pixel and second fill_req raised mid-redraw.
    salt = 3'($urandom);
    rx = 8'($urandom_range(0, 159));
    ry = 7'($urandom_range(0, 119));
    rc = 3'($urandom);
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    run_fill(100, 3000, 0, rx, ry, rc);
    tick();
    check_pixel("stalled_pixel", rx, ry, rc);
    px_req = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("no_refill", {plot, fill_busy, fill_done, px_ack}, 64'd0);
    end

    // Reset at the 5000th redraw plot, then a fresh redraw restarts from (0,0).
    salt = 3'($urandom);
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    run_fill(0, 0, 5001, '0, '0, '0);
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    run_fill(0, 0, 300, '0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plot_scheduler.md
PLOT_SCHEDULER -- requirements
Module: plot_scheduler

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high, with ports named clock and reset.
REQ-002 clock  input  1  system clock (50 MHz), all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high; clears all state on the next clock edge.
REQ-004 fill_req  input  1  one-cycle pulse requesting a full-screen redraw from the image ROM.
REQ-005 fill_busy  output  1  high while a redraw is in progress.
REQ-006 fill_done  output  1  one-cycle pulse coincident with the last redraw plot.
REQ-007 px_req  input  1  single-pixel write request, held until px_ack.
REQ-008 px_x  input  8  pixel column, 0..159.
REQ-009 px_y  input  7  pixel row, 0..119.
REQ-010 px_colour  input  3  pixel colour, RGB 1 bit each.
REQ-011 px_ack  output  1  one-cycle pulse; request accepted and plotted this cycle.
REQ-012 rom_addr  output  15  image ROM address = y*160 + x.
REQ-013 rom_data  input  3  ROM colour, valid exactly 1 cycle after rom_addr.
REQ-014 plot  output  1  framebuffer write strobe.
REQ-015 x  output  8; y  output  7; colour  output  3: framebuffer write coordinate and colour.

Function
REQ-016 The block SHALL arbitrate the single framebuffer write port between the redraw engine and pixel requesters; all outputs are registered.
REQ-017 States SHALL be IDLE, FILL, DRAIN, PIXEL.
REQ-018 IDLE with px_req=1 -> PIXEL; IDLE with fill_req=1 and px_req=0 -> FILL.
REQ-019 IDLE with both asserted SHALL serve the pixel first, latch fill_req as pending, and enter FILL on the cycle after PIXEL.
REQ-020 PIXEL SHALL last one cycle: plot=1, px_ack=1, x/y/colour = values captured in IDLE; then -> IDLE (or FILL if pending).
REQ-021 FILL SHALL scan raster order, x 0..159 inner, y 0..119 outer, issuing one rom_addr per cycle for 19200 cycles.
REQ-022 Each plot in a redraw SHALL occur 1 cycle after its rom_addr, with x/y delayed to match and colour = rom_data.
REQ-023 After address (159,119) the FSM SHALL enter DRAIN for 1 cycle to emit the last plot, then -> IDLE.
REQ-024 For fill_req accepted at cycle t: fill_busy high t+1..t+19201; plot high contiguously t+2..t+19201; fill_done high only at t+19201.
REQ-025 During FILL/DRAIN, px_req SHALL stall (no px_ack) and be served on the first IDLE cycle after.
REQ-026 fill_req during FILL/DRAIN SHALL be ignored, not queued.
REQ-027 x counter SHALL wrap 159->0 with y increment; y SHALL never exceed 119; rom_addr SHALL never exceed 19199.
REQ-028 px_x >159 or px_y >119 SHALL be acknowledged without a plot (plot=0 in that PIXEL cycle).

Reset
REQ-029 Reset SHALL force state IDLE, clear pending fill and counters, and drive plot, px_ack, fill_busy, fill_done to 0 and x, y, colour, rom_addr to 0.
REQ-030 Reset mid-redraw SHALL abort it: plot=0 from the cycle after the reset edge, no fill_done.

Structure
REQ-031 A shared package SHALL hold SCREEN_W=160, SCREEN_H=120, PIXELS=19200, ROM_LATENCY=1, the state enumeration, and colour constants (BLACK=000, RED=100, CYAN=011, WHITE=111).
REQ-032 One sub-module, raster_counter, SHALL provide x/y counting with wrap, clear, enable, and a last-pixel flag.

Verification
REQ-033 Reset, then one-cycle fill_req at t with a ROM model returning addr[2:0] -> 19200 plots t+2..t+19201, pixel (5,0) colour 101, fill_done only at t+19201.
REQ-034 In IDLE, px_req with (10,20,100) -> px_ack and plot the next cycle with x=10, y=20, colour=100; px_ack exactly once.
REQ-035 fill_req and px_req in the same cycle -> pixel plotted first, then FILL starts the following cycle without fill_req being re-asserted.
REQ-036 px_req raised mid-redraw -> no px_ack until the cycle after fill_done; then acknowledged; second fill_req mid-redraw causes no second redraw.
REQ-037 reset asserted at redraw plot 5000 -> plot=0 from the next cycle, fill_busy=0, no fill_done; a new fill_req restarts at (0,0).
REQ-038 px_req with (160,0,111) -> px_ack=1 with plot=0.
